// File: rtl/systolic_sequencer_if.sv
// Bus between the systolic sequencer and its surroundings: the host handshake
// (ap_start/ap_done/busy/err), the instruction memory, the operand memories,
// the PE array and the output memory.
//   master : the sequencer side (drives addresses, enables and handshake outputs)
//   slave  : the memory/array/host side
interface systolic_sequencer_if;
  logic        ap_start;
  logic        ap_done;
  logic        busy;
  logic        err;
  logic [2:0]  inst_addr;
  logic [4:0]  inst_data;
  logic [4:0]  curr_inst;
  logic [7:0]  mem_col;
  logic        mem_rd;
  logic        arr_clear;
  logic        arr_en;
  logic [3:0]  res_sel;
  logic [31:0] res_data;
  logic [6:0]  out_addr;
  logic [31:0] out_data;
  logic        out_we;

  modport master (
    input  ap_start, inst_data, res_data,
    output ap_done, busy, err, inst_addr, curr_inst, mem_col, mem_rd,
           arr_clear, arr_en, res_sel, out_addr, out_data, out_we
  );

  modport slave (
    output ap_start, inst_data, res_data,
    input  ap_done, busy, err, inst_addr, curr_inst, mem_col, mem_rd,
           arr_clear, arr_en, res_sel, out_addr, out_data, out_we
  );
endinterface

// File: rtl/systolic_sequencer.sv
// Control FSM for a 4x4 systolic PE array. On ap_start it walks the
// instruction memory; each nonzero instruction x runs one 4 x x by x x 4
// product: clear the array, stream L pre-skewed operand columns from memA/memB,
// flush one step, then drain the 16 accumulators into the output memory.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : master side of systolic_sequencer_if (handshake, inst/operand
//          memory reads, array control, result readout, output writes)
module systolic_sequencer #(
  parameter int unsigned COLS  = 256,
  parameter int unsigned NINST = 8
) (
  input logic                  clk,
  input logic                  rst,
  systolic_sequencer_if.master bus
);

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StFetch  = 4'd1;
  localparam logic [3:0] StCheck  = 4'd2;
  localparam logic [3:0] StClear  = 4'd3;
  localparam logic [3:0] StStream = 4'd4;
  localparam logic [3:0] StFlush  = 4'd5;
  localparam logic [3:0] StDrain  = 4'd6;
  localparam logic [3:0] StNext   = 4'd7;
  localparam logic [3:0] StDone   = 4'd8;

  localparam logic [9:0] ColsLim = 10'(COLS);
  localparam logic [3:0] KLast   = 4'(NINST - 1);

  logic [3:0] state_q, state_d;
  logic [3:0] k_q, k_d;
  logic [8:0] col_q, col_d;
  logic [5:0] cnt_q, cnt_d;
  logic [4:0] curr_inst_q, curr_inst_d;
  logic       err_q, err_d;
  logic       arr_en_q;

  logic [5:0] chk_len;
  logic [5:0] run_len;
  logic       chk_ovf;

  // Columns used by one instruction; the first one carries one less pad column.
  function automatic logic [5:0] inst_len(input logic [4:0] x, input logic first);
    return {1'b0, x} + (first ? 6'd6 : 6'd7);
  endfunction

  assign chk_len = inst_len(bus.inst_data, k_q == 4'd0);
  assign run_len = inst_len(curr_inst_q, k_q == 4'd0);
  assign chk_ovf = ({1'b0, col_q} + {4'b0, chk_len}) > ColsLim;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    curr_inst_d = curr_inst_q;
    err_d       = err_q;
    case (state_q)
      StIdle: begin
        if (bus.ap_start) begin
          k_d     = 4'd0;
          col_d   = 9'd0;
          cnt_d   = 6'd0;
          err_d   = 1'b0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StCheck;
      StCheck: begin
        curr_inst_d = bus.inst_data;
        if (bus.inst_data == 5'd0) begin
          state_d = StDone;
        end else if (chk_ovf) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StClear;
        end
      end
      StClear: begin
        cnt_d   = 6'd0;
        state_d = StStream;
      end
      StStream: begin
        if (cnt_q == run_len - 6'd1) begin
          cnt_d   = 6'd0;
          state_d = StFlush;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StFlush: begin
        cnt_d   = 6'd0;
        state_d = StDrain;
      end
      StDrain: begin
        if (cnt_q == 6'd15) begin
          cnt_d   = 6'd0;
          state_d = StNext;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StNext: begin
        col_d   = col_q + {3'b0, run_len};
        k_d     = k_q + 4'd1;
        state_d = (k_q == KLast) ? StDone : StFetch;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      k_q         <= 4'd0;
      col_q       <= 9'd0;
      cnt_q       <= 6'd0;
      curr_inst_q <= 5'd0;
      err_q       <= 1'b0;
      arr_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      curr_inst_q <= curr_inst_d;
      err_q       <= err_d;
      // Operand data arrives one cycle after the read, so the array steps one cycle late.
      arr_en_q    <= (state_q == StStream);
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.ap_done   = (state_q == StDone);
  assign bus.err       = err_q;
  assign bus.curr_inst = curr_inst_q;
  // Once k runs off the end, hold the last address instead of wrapping to 0.
  assign bus.inst_addr = k_q[3] ? 3'd7 : k_q[2:0];
  assign bus.mem_rd    = (state_q == StStream);
  assign bus.mem_col   = (state_q == StStream) ? (col_q[7:0] + {2'b0, cnt_q}) : 8'd0;
  assign bus.arr_clear = (state_q == StClear);
  assign bus.arr_en    = arr_en_q;
  assign bus.out_we    = (state_q == StDrain);
  assign bus.res_sel   = (state_q == StDrain) ? cnt_q[3:0] : 4'd0;
  assign bus.out_addr  = (state_q == StDrain) ? {k_q[2:0], cnt_q[3:0]} : 7'd0;
  assign bus.out_data  = bus.res_data;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: behavioural instruction/operand memories and a
// simple accumulate-per-step PE array; expected cycle counts, column sweep and
// output-memory contents come from a program-level model of the sequencer.
module tb_systolic_sequencer;
  localparam int Cols = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_sequencer_if bus ();

  systolic_sequencer #(
    .COLS (256),
    .NINST(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [4:0]  inst_mem [8];
  logic [4:0]  prog     [8];
  logic [7:0]  mem_a    [4][Cols];
  logic [7:0]  mem_b    [4][Cols];
  logic [7:0]  rd_a     [4];
  logic [7:0]  rd_b     [4];
  logic [31:0] acc      [16];
  logic [31:0] got_out  [128];
  logic [31:0] exp_out  [128];
  logic [7:0]  rd_q     [$];

  int ncomp = 0;
  int nfail = 0;

  // Environment: synchronous memories and an array that accumulates a*b per step.
  always @(posedge clk) begin
    bus.inst_data <= inst_mem[bus.inst_addr];
    if (bus.mem_rd) begin
      for (int r = 0; r < 4; r++) begin
        rd_a[r] <= mem_a[r][bus.mem_col];
        rd_b[r] <= mem_b[r][bus.mem_col];
      end
    end
    for (int i = 0; i < 16; i++) begin
      if (bus.arr_clear) acc[i] <= 32'd0;
      else if (bus.arr_en) acc[i] <= acc[i] + 32'(rd_a[i / 4]) * 32'(rd_b[i % 4]);
    end
  end

  assign bus.res_data = acc[bus.res_sel];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    ncomp++;
    assert (obs === exp_v)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic fill_mem();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < Cols; c++) begin
        mem_a[r][c] = 8'($urandom);
        mem_b[r][c] = 8'($urandom);
      end
    end
    for (int k = 0; k < 8; k++) inst_mem[k] = prog[k];
  endtask

  // Runs prog from ap_start to ap_done and checks it against the program-level model.
  task automatic run_prog(input string tag, input int pulse_cyc);
    int   col, n_done, exp_cyc, exp_rd, x, len, done_cyc;
    logic exp_err, seen, busy_at_done;
    logic [4:0]  exp_ci;
    logic [31:0] s;
    int   wr_cnt;
    fill_mem();
    col = 0; n_done = 0; exp_cyc = 0; exp_rd = 0; exp_err = 1'b0; exp_ci = 5'd0;
    for (int a = 0; a < 128; a++) begin
      exp_out[a] = 32'hDEAD_BEEF;
      got_out[a] = 32'hDEAD_BEEF;
    end
    for (int k = 0; k < 8; k++) begin
      x = int'(prog[k]);
      exp_ci = prog[k];
      if (x == 0) begin exp_cyc += 3; break; end
      len = x + ((k == 0) ? 6 : 7);
      if (col + len > Cols) begin exp_err = 1'b1; exp_cyc += 3; break; end
      for (int i = 0; i < 16; i++) begin
        s = 32'd0;
        for (int c = col; c < col + len; c++) s += 32'(mem_a[i / 4][c]) * 32'(mem_b[i % 4][c]);
        exp_out[16 * k + i] = s;
      end
      col += len; exp_rd += len; n_done++; exp_cyc += len + 21;
      if (k == 7) exp_cyc += 1;
    end

    rd_q.delete();
    wr_cnt = 0; seen = 1'b0; done_cyc = 0; busy_at_done = 1'b0;
    @(negedge clk);
    bus.ap_start = 1'b1;
    @(posedge clk);
    #1 bus.ap_start = 1'b0;
    for (int t = 1; t <= 2500 && !seen; t++) begin
      @(negedge clk);
      bus.ap_start = (t == pulse_cyc);
      if (bus.mem_rd) rd_q.push_back(bus.mem_col);
      if (bus.out_we) begin
        wr_cnt++;
        got_out[bus.out_addr] = bus.out_data;
      end
      if (bus.ap_done) begin
        seen = 1'b1;
        done_cyc = t;
        busy_at_done = bus.busy;
      end
    end
    bus.ap_start = 1'b0;
    chk($sformatf("%s.done_seen", tag), 32'(seen), 32'd1);
    chk($sformatf("%s.done_cycle", tag), 32'(done_cyc), 32'(exp_cyc));
    chk($sformatf("%s.busy_at_done", tag), 32'(busy_at_done), 32'd1);
    chk($sformatf("%s.err", tag), 32'(bus.err), 32'(exp_err));
    chk($sformatf("%s.curr_inst", tag), 32'(bus.curr_inst), 32'(exp_ci));
    chk($sformatf("%s.rd_cycles", tag), 32'(rd_q.size()), 32'(exp_rd));
    chk($sformatf("%s.wr_count", tag), 32'(wr_cnt), 32'(16 * n_done));
    for (int j = 0; j < rd_q.size(); j++)
      chk($sformatf("%s.mem_col[%0d]", tag, j), 32'(rd_q[j]), 32'(j));
    for (int a = 0; a < 128; a++)
      chk($sformatf("%s.out[%0d]", tag, a), got_out[a], exp_out[a]);
    @(negedge clk);
    chk($sformatf("%s.done_pulse", tag), 32'(bus.ap_done), 32'd0);
    chk($sformatf("%s.idle_busy", tag), 32'(bus.busy), 32'd0);
    chk($sformatf("%s.err_held", tag), 32'(bus.err), 32'(exp_err));
    chk($sformatf("%s.ci_held", tag), 32'(bus.curr_inst), 32'(exp_ci));
  endtask

  task automatic chk_all_zero(input string tag);
    chk($sformatf("%s.busy", tag), 32'(bus.busy), 32'd0);
    chk($sformatf("%s.ap_done", tag), 32'(bus.ap_done), 32'd0);
    chk($sformatf("%s.err", tag), 32'(bus.err), 32'd0);
    chk($sformatf("%s.curr_inst", tag), 32'(bus.curr_inst), 32'd0);
    chk($sformatf("%s.inst_addr", tag), 32'(bus.inst_addr), 32'd0);
    chk($sformatf("%s.mem_col", tag), 32'(bus.mem_col), 32'd0);
    chk($sformatf("%s.mem_rd", tag), 32'(bus.mem_rd), 32'd0);
    chk($sformatf("%s.arr_clear", tag), 32'(bus.arr_clear), 32'd0);
    chk($sformatf("%s.arr_en", tag), 32'(bus.arr_en), 32'd0);
    chk($sformatf("%s.res_sel", tag), 32'(bus.res_sel), 32'd0);
    chk($sformatf("%s.out_addr", tag), 32'(bus.out_addr), 32'd0);
    chk($sformatf("%s.out_we", tag), 32'(bus.out_we), 32'd0);
  endtask

  initial begin
    int zpos;
    bus.ap_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      prog[k] = 5'd0;
      inst_mem[k] = 5'd0;
    end
    #2 rst = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Single x=4 product.
    prog[0] = 5'd4;
    run_prog("single4", 0);

    // Empty program.
    prog[0] = 5'd0;
    run_prog("empty", 0);

    // {4,2,0} with an ap_start pulse during the first DRAIN (cycles 15..30).
    prog[0] = 5'd4; prog[1] = 5'd2; prog[2] = 5'd0;
    run_prog("prog420", 20);

    // Eight x=1 instructions: runs off the end of instruction memory.
    for (int k = 0; k < 8; k++) prog[k] = 5'd1;
    run_prog("all1", 0);

    // Eight x=31 instructions: column overflow at k=6.
    for (int k = 0; k < 8; k++) prog[k] = 5'd31;
    run_prog("all31", 0);

    // Random program with a terminator and a DRAIN-time ap_start pulse.
    for (int k = 0; k < 8; k++) prog[k] = 5'($urandom_range(1, 31));
    zpos = int'($urandom_range(1, 7));
    prog[zpos] = 5'd0;
    run_prog("rand", int'(prog[0]) + 6 + 10);

    // Random program without terminator.
    for (int k = 0; k < 8; k++) prog[k] = 5'($urandom_range(1, 12));
    run_prog("rand_full", 0);

    // Held ap_start on an empty program restarts only after IDLE.
    for (int k = 0; k < 8; k++) inst_mem[k] = 5'd0;
    @(negedge clk);
    bus.ap_start = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      chk($sformatf("held.ap_done[%0d]", t), 32'(bus.ap_done), 32'((t == 3) || (t == 7)));
      if (t == 8) bus.ap_start = 1'b0;
    end
    @(negedge clk);
    chk("held.idle_busy", 32'(bus.busy), 32'd0);

    // Reset in the middle of STREAM.
    for (int k = 0; k < 8; k++) prog[k] = 5'd0;
    prog[0] = 5'd4;
    fill_mem();
    @(negedge clk);
    bus.ap_start = 1'b1;
    @(posedge clk);
    #1 bus.ap_start = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst.in_stream", 32'(bus.mem_rd), 32'd1);
    #2 rst = 1'b0;
    #1 chk_all_zero("rst_mid");
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk($sformatf("rst_hold.out_we[%0d]", t), 32'(bus.out_we), 32'd0);
      chk($sformatf("rst_hold.ap_done[%0d]", t), 32'(bus.ap_done), 32'd0);
    end
    rst = 1'b1;
    run_prog("after_rst", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
